noc_output_port_sched: RTL and testbench

//  Per-output-port scheduler of the 5-port NoC router; one instance per output (N,S,E,W,L).

---
 rtl/noc_output_port_sched.sv | 219 +++++++++++++++++++++
 tb/tb_noc_output_port_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_port_sched.sv
// ---------------------------------------------------------------------------
// noc_output_port_sched
//   Per-output-port scheduler of the 5-port NoC router (one instance per
//   output N,S,E,W,L). Chooses which input buffer feeds this output and pops
//   that buffer's head flit. The chosen flit goes into a one-entry registered
//   output stage that talks to the link with a valid/ready handshake.
//   Arbitration is round-robin among inputs that request this port. Once a
//   head flit is taken, the input that sent it keeps the port until its tail
//   flit has been popped (wormhole lock).
//
// Parameters
//   FLIT_W   flit width; the top two bits give the flit type:
//            10 head, 00 body, 01 tail, 11 single (head+tail)
//   RR_INIT  input index that has highest priority after reset (0..4)
//
// Ports
//   clk        in   1          clock
//   rst        in   1          synchronous reset, active high
//   req_i      in   5          input k's head flit is routed here (0..4 = N,S,E,W,L)
//   nempty_i   in   5          input buffer k is non-empty
//   head_i     in   5*FLIT_W   head flits; input k at [k*FLIT_W +: FLIT_W]
//   pop_req_o  out  5          one-hot-or-zero pop of input k at this edge
//   data_o     out  FLIT_W     output-stage flit
//   valid_o    out  1          data_o valid
//   ready_i    in   1          downstream takes data_o when valid_o & ready_i
//   err_o      out  1          sticky protocol error
//   flit_cnt_o out  16         flits transferred downstream, wraps mod 2^16
// ---------------------------------------------------------------------------
module noc_output_port_sched #(
  parameter int unsigned FLIT_W  = 16,
  parameter int unsigned RR_INIT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          req_i,
  input  logic [4:0]          nempty_i,
  input  logic [5*FLIT_W-1:0] head_i,
  output logic [4:0]          pop_req_o,
  output logic [FLIT_W-1:0]   data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                err_o,
  output logic [15:0]         flit_cnt_o
);

  localparam int unsigned NP = 5;

  localparam logic [1:0] TYPE_BODY   = 2'b00;
  localparam logic [1:0] TYPE_TAIL   = 2'b01;
  localparam logic [1:0] TYPE_HEAD   = 2'b10;
  localparam logic [1:0] TYPE_SINGLE = 2'b11;

  localparam logic [2:0] RR_RST = 3'(RR_INIT % NP);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  rr_q, rr_d;
  logic [2:0]  owner_q, owner_d;

  logic [FLIT_W-1:0] flit  [NP];
  logic [1:0]        ftype [NP];
  logic [NP-1:0]     eligible;
  logic [NP-1:0]     bad_head;

  logic              can_load;
  logic              found;
  logic [2:0]        pick;
  logic [3:0]        scan_idx;
  logic              pop_fire;
  logic [2:0]        pop_idx;
  logic              err_set;
  logic [FLIT_W-1:0] pop_flit;

  // Increment modulo the number of inputs.
  function automatic logic [2:0] inc5(input logic [2:0] x);
    return (x == 3'd4) ? 3'd0 : x + 3'd1;
  endfunction

  // Split the flat head bus and classify each head flit.
  always_comb begin
    for (int unsigned k = 0; k < NP; k++) begin
      flit[k]  = head_i[k*FLIT_W +: FLIT_W];
      ftype[k] = head_i[k*FLIT_W + FLIT_W - 2 +: 2];
    end
  end

  // A packet may only start with a head or single flit; a body/tail flit at a
  // requesting head while idle means the upstream framing is broken.
  always_comb begin
    for (int unsigned k = 0; k < NP; k++) begin
      eligible[k] = req_i[k] & nempty_i[k] & ftype[k][1];
      bad_head[k] = req_i[k] & nempty_i[k] & ~ftype[k][1];
    end
  end

  // Output stage may accept a new flit when empty or emptying this cycle.
  assign can_load = ~valid_o | ready_i;

  // Round-robin search: first eligible input starting at rr_q.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      scan_idx = {1'b0, rr_q} + 4'(i);
      if (scan_idx >= 4'(NP)) begin
        scan_idx = scan_idx - 4'(NP);
      end
      if (!found && eligible[scan_idx[2:0]]) begin
        found = 1'b1;
        pick  = scan_idx[2:0];
      end
    end
  end

  // Next-state and pop decision.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    pop_fire = 1'b0;
    pop_idx  = owner_q;
    err_set  = 1'b0;

    case (state_q)
      S_IDLE: begin
        err_set = |bad_head;
        if (found && can_load) begin
          pop_fire = 1'b1;
          pop_idx  = pick;
          if (ftype[pick] == TYPE_SINGLE) begin
            rr_d = inc5(pick);
          end else begin
            state_d = S_LOCKED;
            owner_d = pick;
          end
        end
      end

      S_LOCKED: begin
        if (nempty_i[owner_q] && can_load) begin
          pop_fire = 1'b1;
          pop_idx  = owner_q;
          case (ftype[owner_q])
            TYPE_TAIL: begin
              state_d = S_IDLE;
              rr_d    = inc5(owner_q);
            end
            TYPE_HEAD, TYPE_SINGLE: begin
              // Flit is still forwarded; the lock is kept so the rest of the
              // owner's stream is not interleaved with other inputs.
              err_set = 1'b1;
            end
            TYPE_BODY: begin
              state_d = S_LOCKED;
            end
            default: begin
              state_d = S_LOCKED;
            end
          endcase
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pop request is combinational and suppressed while reset is asserted.
  always_comb begin
    for (int unsigned k = 0; k < NP; k++) begin
      pop_req_o[k] = pop_fire & ~rst & (pop_idx == 3'(k));
    end
  end

  assign pop_flit = flit[pop_idx];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= RR_RST;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  // Output stage, error flag and transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o     <= '0;
      valid_o    <= 1'b0;
      err_o      <= 1'b0;
      flit_cnt_o <= '0;
    end else begin
      if (pop_fire) begin
        data_o  <= pop_flit;
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
      if (valid_o && ready_i) begin
        flit_cnt_o <= flit_cnt_o + 16'd1;
      end
      if (err_set) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_output_port_sched.sv
module tb_noc_output_port_sched;

  logic        clk;
  logic        rst;
  logic [4:0]  req_i;
  logic [4:0]  nempty_i;
  logic [79:0] head_i;
  logic [4:0]  pop_req_o;
  logic [15:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        err_o;
  logic [15:0] flit_cnt_o;

  int n_chk;
  int n_fail;

  noc_output_port_sched #(
    .FLIT_W  (16),
    .RR_INIT (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .nempty_i   (nempty_i),
    .head_i     (head_i),
    .pop_req_o  (pop_req_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .err_o      (err_o),
    .flit_cnt_o (flit_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  req;
    logic [4:0]  nempty;
    logic [79:0] heads;
    logic        ready;
    logic        chk;
    logic [4:0]  pop;
    logic        valid;
    logic [15:0] data;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic logic [79:0] mk(input logic [15:0] n, input logic [15:0] s,
                                     input logic [15:0] e, input logic [15:0] w,
                                     input logic [15:0] l);
    return {l, w, e, s, n};
  endfunction

  task automatic add(input logic rs, input logic [4:0] rq, input logic [4:0] ne,
                     input logic [79:0] hd, input logic rdy, input logic ck,
                     input logic [4:0] pp, input logic vl, input logic [15:0] dt,
                     input logic er, input logic [15:0] ct);
    vec_t t;
    t.rst = rs; t.req = rq; t.nempty = ne; t.heads = hd; t.ready = rdy;
    t.chk = ck; t.pop = pp; t.valid = vl; t.data = dt; t.err = er; t.cnt = ct;
    vq.push_back(t);
  endtask

  task automatic drive(input logic rs, input logic [4:0] rq, input logic [4:0] ne,
                       input logic [79:0] hd, input logic rdy);
    rst = rs; req_i = rq; nempty_i = ne; head_i = hd; ready_i = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input string fld,
                     input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", tag, fld, act, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [4:0] pp, input logic vl,
                     input logic [15:0] dt, input logic er, input logic [15:0] ct);
    cmp(tag, "pop_req", {11'd0, pop_req_o}, {11'd0, pp});
    cmp(tag, "valid",   {15'd0, valid_o},   {15'd0, vl});
    cmp(tag, "data",    data_o,             dt);
    cmp(tag, "err",     {15'd0, err_o},     {15'd0, er});
    cmp(tag, "cnt",     flit_cnt_o,         ct);
  endtask

  initial begin
    logic [79:0] h2;
    vec_t        v;
    n_chk  = 0;
    n_fail = 0;

    // Reset state
    drive(1'b1, '0, '0, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("reset", 5'b00000, 1'b0, 16'h0000, 1'b0, 16'd0);
    tick();

    // Single flit from N: pop now, data next cycle, count the cycle after
    add(0, 5'b00001, 5'b00001, mk(16'hC011, 0, 0, 0, 0), 1, 1, 5'b00001, 0, 16'h0000, 0, 16'd0);
    add(0, 5'b00000, 5'b00000, '0, 1, 1, 5'b00000, 1, 16'hC011, 0, 16'd0);
    add(0, 5'b00000, 5'b00000, '0, 1, 1, 5'b00000, 0, 16'hC011, 0, 16'd1);

    // Round robin among N,E,L with single flits, back-to-back
    add(1, 5'b00000, 5'b00000, '0, 1, 0, 5'b00000, 0, 16'h0000, 0, 16'd0);
    h2 = mk(16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005);
    add(0, 5'b10101, 5'b10101, h2, 1, 1, 5'b00001, 0, 16'h0000, 0, 16'd0);
    add(0, 5'b10101, 5'b10101, h2, 1, 1, 5'b00100, 1, 16'hC001, 0, 16'd0);
    add(0, 5'b10101, 5'b10101, h2, 1, 1, 5'b10000, 1, 16'hC003, 0, 16'd1);
    add(0, 5'b10101, 5'b10101, h2, 1, 1, 5'b00001, 1, 16'hC005, 0, 16'd2);
    add(0, 5'b10101, 5'b10101, h2, 1, 1, 5'b00100, 1, 16'hC001, 0, 16'd3);
    add(0, 5'b10101, 5'b10101, h2, 1, 1, 5'b10000, 1, 16'hC003, 0, 16'd4);
    add(0, 5'b00000, 5'b00000, '0, 1, 1, 5'b00000, 1, 16'hC005, 0, 16'd5);
    add(0, 5'b00000, 5'b00000, '0, 1, 1, 5'b00000, 0, 16'hC005, 0, 16'd6);

    // S packet head/body/tail holds the port against W's single flit
    add(0, 5'b01010, 5'b01010, mk(0, 16'h8022, 0, 16'hC0AA, 0), 1, 1, 5'b00010, 0, 16'hC005, 0, 16'd6);
    add(0, 5'b01010, 5'b01010, mk(0, 16'h0023, 0, 16'hC0AA, 0), 1, 1, 5'b00010, 1, 16'h8022, 0, 16'd6);
    add(0, 5'b01010, 5'b01010, mk(0, 16'h4024, 0, 16'hC0AA, 0), 1, 1, 5'b00010, 1, 16'h0023, 0, 16'd7);
    add(0, 5'b01000, 5'b01000, mk(0, 0, 0, 16'hC0AA, 0), 1, 1, 5'b01000, 1, 16'h4024, 0, 16'd8);
    add(0, 5'b00000, 5'b00000, '0, 1, 1, 5'b00000, 1, 16'hC0AA, 0, 16'd9);
    add(0, 5'b00000, 5'b00000, '0, 1, 1, 5'b00000, 0, 16'hC0AA, 0, 16'd10);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      drive(v.rst, v.req, v.nempty, v.heads, v.ready);
      #2;
      if (v.chk) chk($sformatf("row%0d", i), v.pop, v.valid, v.data, v.err, v.cnt);
      tick();
    end

    // Owner N empties for 3 cycles while E requests
    drive(0, 5'b00101, 5'b00101, mk(16'h8031, 0, 16'hC0EE, 0, 0), 1); #2;
    chk("lock_a", 5'b00001, 0, 16'hC0AA, 0, 16'd10); tick();
    drive(0, 5'b00101, 5'b00100, mk(0, 0, 16'hC0EE, 0, 0), 1); #2;
    chk("lock_b", 5'b00000, 1, 16'h8031, 0, 16'd10); tick();
    #2;
    chk("lock_c", 5'b00000, 0, 16'h8031, 0, 16'd11); tick();
    #2;
    chk("lock_d", 5'b00000, 0, 16'h8031, 0, 16'd11); tick();
    drive(0, 5'b00101, 5'b00101, mk(16'h4032, 0, 16'hC0EE, 0, 0), 1); #2;
    chk("lock_e", 5'b00001, 0, 16'h8031, 0, 16'd11); tick();
    drive(0, 5'b00100, 5'b00100, mk(0, 0, 16'hC0EE, 0, 0), 1); #2;
    chk("lock_f", 5'b00100, 1, 16'h4032, 0, 16'd11); tick();
    drive(0, '0, '0, '0, 1); #2;
    chk("lock_g", 5'b00000, 1, 16'hC0EE, 0, 16'd12); tick();

    // Downstream stall for 4 cycles
    drive(0, 5'b00001, 5'b00001, mk(16'hC0B1, 0, 0, 0, 0), 1); #2;
    chk("stall_h", 5'b00001, 0, 16'hC0EE, 0, 16'd13); tick();
    for (int s = 0; s < 4; s++) begin
      drive(0, 5'b00001, 5'b00001, mk(16'hC0B2, 0, 0, 0, 0), 0); #2;
      chk($sformatf("stall%0d", s), 5'b00000, 1, 16'hC0B1, 0, 16'd13); tick();
    end
    drive(0, 5'b00001, 5'b00001, mk(16'hC0B2, 0, 0, 0, 0), 1); #2;
    chk("stall_m", 5'b00001, 1, 16'hC0B1, 0, 16'd13); tick();
    drive(0, '0, '0, '0, 1); #2;
    chk("stall_n", 5'b00000, 1, 16'hC0B2, 0, 16'd14); tick();
    #2;
    chk("stall_o", 5'b00000, 0, 16'hC0B2, 0, 16'd15); tick();

    // Body flit at a requesting head while idle
    drive(0, 5'b00010, 5'b00010, mk(0, 16'h0055, 0, 0, 0), 1); #2;
    chk("err_p", 5'b00000, 0, 16'hC0B2, 0, 16'd15); tick();
    drive(0, '0, '0, '0, 1); #2;
    chk("err_q", 5'b00000, 0, 16'hC0B2, 1, 16'd15); tick();

    // Reset in the middle of a packet
    drive(0, 5'b00001, 5'b00001, mk(16'h8061, 0, 0, 0, 0), 1); #2;
    chk("mrst_r", 5'b00001, 0, 16'hC0B2, 1, 16'd15); tick();
    drive(1, 5'b00001, 5'b00001, mk(16'h0062, 0, 0, 0, 0), 0); #2;
    chk("mrst_s", 5'b00000, 1, 16'h8061, 1, 16'd15); tick();
    drive(0, 5'b00001, 5'b00001, mk(16'h0062, 0, 0, 0, 0), 1); #2;
    chk("mrst_t", 5'b00000, 0, 16'h0000, 0, 16'd0); tick();
    drive(0, '0, '0, '0, 1); #2;
    chk("mrst_u", 5'b00000, 0, 16'h0000, 1, 16'd0); tick();

    // Transfer counter wrap
    drive(1, '0, '0, '0, 1); tick();
    drive(0, 5'b00001, 5'b00001, mk(16'hC0FF, 0, 0, 0, 0), 1); #2;
    chk("wrap_0", 5'b00001, 0, 16'h0000, 0, 16'd0);
    for (int c = 0; c < 65536; c++) begin
      @(posedge clk);
    end
    #3;
    chk("wrap_ffff", 5'b00001, 1, 16'hC0FF, 0, 16'hFFFF);
    tick();
    #2;
    chk("wrap_zero", 5'b00001, 1, 16'hC0FF, 0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
